// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, serial FSM state encoding, default width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int   ALU_WIDTH = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_subtract_if.sv
// Request/result bundle of the bit-serial add/subtract unit.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the unit is idle or done.
interface serial_add_subtract_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
) ();

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, op, a, b, c_in,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, op, a, b, c_in,
        output busy, done, sum, c_out, overflow
    );

endinterface

// File: rtl/full_adder_bit.sv
// One-bit full adder cell; the only arithmetic in the serial unit.
// Latency: combinational.
// Backpressure: none.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half;

    assign half = a ^ b;
    assign s    = half ^ cin;
    assign cout = (a & b) | (cin & half);

endmodule

// File: rtl/serial_add_subtract.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one bit per clock through a single full adder.
// Latency: start sampled at edge N -> done pulse in the cycle after edge N+WIDTH.
// Backpressure: start ignored while busy; no queueing, operands never re-sampled mid-operation.
module serial_add_subtract
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic clk,
    input  logic reset_n,
    serial_add_subtract_if.slave bus
);

    localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] shadow;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             msb_cin_q;

    logic             fa_s;
    logic             fa_cout;
    logic             accept;
    logic             shifting;
    logic             last_bit;
    logic             is_sub;

    assign accept   = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    assign shifting = (state == ST_SHIFT);
    assign last_bit = shifting && (cnt == LAST_BIT);
    assign is_sub   = (bus.op == OP_SUB);

    full_adder_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST_BIT) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = bus.start ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Subtract is a + ~b + !borrow_in, so inversion happens once at accept time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            shadow    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum_q     <= '0;
            c_out_q   <= 1'b0;
            msb_cin_q <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= is_sub ? ~bus.b : bus.b;
            carry <= is_sub ? ~bus.c_in : bus.c_in;
            cnt   <= '0;
        end else if (shifting) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            shadow <= {fa_s, shadow[WIDTH-1:1]};
            carry  <= fa_cout;
            if (last_bit) begin
                sum_q     <= {fa_s, shadow[WIDTH-1:1]};
                c_out_q   <= fa_cout;
                msb_cin_q <= carry;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.busy     = shifting;
    assign bus.done     = (state == ST_DONE);
    assign bus.sum      = sum_q;
    assign bus.c_out    = c_out_q;
    assign bus.overflow = msb_cin_q ^ c_out_q;

endmodule

// File: tb/tb_serial_add_subtract.sv
// Directed bench for the bit-serial add/subtract unit with a reference model check.
module tb_serial_add_subtract;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [9:0] exp;   // {c_out, overflow, sum}
    } vec_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    serial_add_subtract_if #(.WIDTH(8)) bus ();

    serial_add_subtract #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ref_model(input logic op, input logic [7:0] a,
                                             input logic [7:0] b, input logic cin);
        logic [7:0] bb;
        logic       cc;
        logic [8:0] full;
        logic [7:0] low;
        bb   = op ? ~b : b;
        cc   = op ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, cc};
        low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'd0, cc};
        return {full[8], low[7] ^ full[8], full[7:0]};
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.c_in  = cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // edges counts the accept edge as 1; returns #1 after the edge that raises done.
    task automatic wait_done(input int edges_in, output int edges, output int busy_cyc,
                             output bit timeout);
        edges    = edges_in;
        busy_cyc = 0;
        timeout  = 1'b0;
        while (!bus.done) begin
            if (edges > 40) begin
                timeout = 1'b1;
                break;
            end
            if (bus.busy) busy_cyc++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.c_in  = 1'b0;
        #23;
        checks++;
        if ({bus.busy, bus.done, bus.c_out, bus.overflow, bus.sum} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b c_out=%b ovf=%b sum=%h, required all 0",
                     bus.busy, bus.done, bus.c_out, bus.overflow, bus.sum);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_add_basic;
        int e, bc;
        bit to;
        issue(1'b0, 8'h01, 8'h04, 1'b0);
        wait_done(1, e, bc, to);
        checks++;
        if (to !== 1'b0 || e !== 9) begin
            errors++;
            $display("FAIL add_latency: edges=%0d timeout=%0b, required 9", e, to);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL add_busy_cycles: got %0d, required 8", bc);
        end
        checks++;
        if ({bus.c_out, bus.overflow, bus.sum} !== {1'b0, 1'b0, 8'h05}) begin
            errors++;
            $display("FAIL add_result: c_out=%b ovf=%b sum=%h, required 0 0 05",
                     bus.c_out, bus.overflow, bus.sum);
        end
        checks++;
        if ({bus.c_out, bus.overflow, bus.sum} !== ref_model(1'b0, 8'h01, 8'h04, 1'b0)) begin
            errors++;
            $display("FAIL add_model: got %h, required %h",
                     {bus.c_out, bus.overflow, bus.sum}, ref_model(1'b0, 8'h01, 8'h04, 1'b0));
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.sum !== 8'h05) begin
            errors++;
            $display("FAIL done_pulse_hold: done=%b sum=%h, required 0 05", bus.done, bus.sum);
        end
    endtask

    task automatic test_subtract_overflow;
        vec_t v[6];
        int e, bc;
        bit to;
        v[0] = '{1'b1, 8'h81, 8'h84, 1'b0, {1'b0, 1'b0, 8'hFD}};
        v[1] = '{1'b1, 8'h85, 8'h05, 1'b0, {1'b1, 1'b0, 8'h80}};
        v[2] = '{1'b1, 8'h05, 8'h85, 1'b0, {1'b0, 1'b1, 8'h80}};
        v[3] = '{1'b0, 8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 8'h80}};
        v[4] = '{1'b0, 8'hFF, 8'h81, 1'b0, {1'b1, 1'b0, 8'h80}};
        v[5] = '{1'b1, 8'h10, 8'h01, 1'b1, {1'b1, 1'b0, 8'h0E}};
        for (int i = 0; i < 6; i++) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].cin);
            wait_done(1, e, bc, to);
            checks++;
            if (to !== 1'b0 || e !== 9) begin
                errors++;
                $display("FAIL vec%0d_latency: edges=%0d timeout=%0b, required 9", i, e, to);
            end
            checks++;
            if ({bus.c_out, bus.overflow, bus.sum} !== v[i].exp) begin
                errors++;
                $display("FAIL vec%0d_result: {c_out,ovf,sum}=%h, required %h",
                         i, {bus.c_out, bus.overflow, bus.sum}, v[i].exp);
            end
            checks++;
            if ({bus.c_out, bus.overflow, bus.sum} !== ref_model(v[i].op, v[i].a, v[i].b, v[i].cin)) begin
                errors++;
                $display("FAIL vec%0d_model: got %h, required %h", i,
                         {bus.c_out, bus.overflow, bus.sum},
                         ref_model(v[i].op, v[i].a, v[i].b, v[i].cin));
            end
            // Alternate between returning to idle and issuing straight from done.
            if (i[0]) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_back_to_back;
        int e, bc;
        bit to;
        issue(1'b0, 8'h01, 8'h04, 1'b0);
        wait_done(1, e, bc, to);
        // Still in the done cycle: this start is sampled on the edge leaving done.
        issue(1'b1, 8'hFF, 8'h7E, 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.sum !== 8'h05) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b sum=%h, required 1 05", bus.busy, bus.sum);
        end
        wait_done(1, e, bc, to);
        checks++;
        if (to !== 1'b0 || e !== 9) begin
            errors++;
            $display("FAIL b2b_latency: edges=%0d timeout=%0b, required 9", e, to);
        end
        checks++;
        if ({bus.c_out, bus.overflow, bus.sum} !== {1'b1, 1'b0, 8'h81}) begin
            errors++;
            $display("FAIL b2b_result: c_out=%b ovf=%b sum=%h, required 1 0 81",
                     bus.c_out, bus.overflow, bus.sum);
        end
    endtask

    task automatic test_ignored_start;
        int e, bc, edges;
        bit to;
        @(posedge clk);
        #1;
        issue(1'b0, 8'h7F, 8'h01, 1'b0);
        edges = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                bus.start = 1'b1;
                bus.op    = 1'b1;
                bus.a     = 8'h33;
                bus.b     = 8'h11;
                bus.c_in  = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.sum !== 8'h81) begin
            errors++;
            $display("FAIL ignored_start_hold: busy=%b sum=%h, required 1 81", bus.busy, bus.sum);
        end
        wait_done(edges, e, bc, to);
        checks++;
        if (to !== 1'b0 || e !== 9) begin
            errors++;
            $display("FAIL ignored_start_latency: edges=%0d timeout=%0b, required 9", e, to);
        end
        checks++;
        if ({bus.c_out, bus.overflow, bus.sum} !== {1'b0, 1'b1, 8'h80}) begin
            errors++;
            $display("FAIL ignored_start_result: c_out=%b ovf=%b sum=%h, required 0 1 80",
                     bus.c_out, bus.overflow, bus.sum);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL ignored_start_no_rerun: busy=%b done=%b, required 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_operand_stability;
        int e, bc, edges;
        bit to;
        issue(1'b1, 8'h05, 8'h85, 1'b0);
        edges = 1;
        for (int i = 0; i < 6; i++) begin
            bus.a    = bus.a ^ 8'hFF;
            bus.b    = bus.b + 8'h3C;
            bus.op   = ~bus.op;
            bus.c_in = ~bus.c_in;
            @(posedge clk);
            #1;
            edges++;
        end
        wait_done(edges, e, bc, to);
        checks++;
        if (to !== 1'b0 || e !== 9) begin
            errors++;
            $display("FAIL stability_latency: edges=%0d timeout=%0b, required 9", e, to);
        end
        checks++;
        if ({bus.c_out, bus.overflow, bus.sum} !== {1'b0, 1'b1, 8'h80}) begin
            errors++;
            $display("FAIL stability_result: c_out=%b ovf=%b sum=%h, required 0 1 80",
                     bus.c_out, bus.overflow, bus.sum);
        end
    endtask

    task automatic test_reset_abort;
        int e, bc, done_seen;
        bit to;
        @(posedge clk);
        #1;
        issue(1'b0, 8'h22, 8'h33, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.c_out, bus.overflow, bus.sum} !== 12'h000) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b done=%b c_out=%b ovf=%b sum=%h, required all 0",
                     bus.busy, bus.done, bus.c_out, bus.overflow, bus.sum);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL abort_no_stale_done: active cycles=%0d, required 0", done_seen);
        end
        issue(1'b0, 8'h01, 8'h04, 1'b0);
        wait_done(1, e, bc, to);
        checks++;
        if (to !== 1'b0 || e !== 9) begin
            errors++;
            $display("FAIL post_abort_latency: edges=%0d timeout=%0b, required 9", e, to);
        end
        checks++;
        if ({bus.c_out, bus.overflow, bus.sum} !== {1'b0, 1'b0, 8'h05}) begin
            errors++;
            $display("FAIL post_abort_result: c_out=%b ovf=%b sum=%h, required 0 0 05",
                     bus.c_out, bus.overflow, bus.sum);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_basic();
        test_subtract_overflow();
        test_back_to_back();
        test_ignored_start();
        test_operand_stability();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
